// File: rtl/prompt_sequencer.sv
// Reaction-game round controller: LFSR target pick, timed response window, gap, scoring.
// Build option NO_REPEAT_PROMPT_EN: consecutive prompts within a game never repeat.
module prompt_sequencer #(
  parameter int          RESPONSE_CYCLES = 50000000,
  parameter int          GAP_CYCLES      = 12500000,
  parameter int          MAX_ROUNDS      = 10,
  parameter logic [15:0] DEFAULT_SEED    = 16'hACE1
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [15:0] seed,
  input  logic        start,
  input  logic        btn_valid,
  input  logic [3:0]  btn_onehot,
  output logic [3:0]  prompt,
  output logic        prompt_active,
  output logic        hit,
  output logic        miss,
  output logic [6:0]  score,
  output logic [3:0]  round,
  output logic        game_over
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHOW = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CNT_MAX = (RESPONSE_CYCLES > GAP_CYCLES) ? RESPONSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RESP_LOAD  = CNT_W'(RESPONSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       ROUND_LAST = 4'(MAX_ROUNDS);

  function automatic logic [6:0] sat_inc(input logic [6:0] s);
    return (s == 7'd127) ? s : s + 7'd1;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [3:0]       prompt_q, prompt_d;
  logic             active_q, active_d;
  logic             hit_q, hit_d;
  logic             miss_q, miss_d;
  logic [6:0]       score_q, score_d;
  logic [3:0]       round_q, round_d;
  logic             over_q, over_d;
  logic [3:0]       round_inc;
  logic [1:0]       idx_first;
  logic [1:0]       idx_next;

`ifdef NO_REPEAT_PROMPT_EN
  logic [1:0] prev_idx_q, prev_idx_d;
  // A repeat of the previous round's target is bumped to the neighbouring button.
  assign idx_next = (lfsr_q[1:0] == prev_idx_q) ? lfsr_q[1:0] + 2'd1 : lfsr_q[1:0];
`else
  assign idx_next = lfsr_q[1:0];
`endif

  assign idx_first = lfsr_q[1:0];
  assign round_inc = round_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    prompt_d = prompt_q;
    active_d = active_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    score_d  = score_q;
    round_d  = round_q;
    over_d   = over_q;
`ifdef NO_REPEAT_PROMPT_EN
    prev_idx_d = prev_idx_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_SHOW;
          cnt_d    = RESP_LOAD;
          prompt_d = onehot(idx_first);
          active_d = 1'b1;
          score_d  = 7'd0;
          round_d  = 4'd0;
          over_d   = 1'b0;
`ifdef NO_REPEAT_PROMPT_EN
          prev_idx_d = idx_first;
`endif
        end
      end
      S_SHOW: begin
        // A press on the final window cycle is judged; the timeout loses.
        if (btn_valid || (cnt_q == '0)) begin
          if (btn_valid && (btn_onehot == prompt_q)) begin
            hit_d   = 1'b1;
            score_d = sat_inc(score_q);
          end else begin
            miss_d  = 1'b1;
          end
          state_d  = S_GAP;
          cnt_d    = GAP_LOAD;
          prompt_d = 4'd0;
          active_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          round_d = round_inc;
          if (round_inc == ROUND_LAST) begin
            state_d = S_DONE;
            over_d  = 1'b1;
          end else begin
            state_d  = S_SHOW;
            cnt_d    = RESP_LOAD;
            prompt_d = onehot(idx_next);
            active_d = 1'b1;
`ifdef NO_REPEAT_PROMPT_EN
            prev_idx_d = idx_next;
`endif
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lfsr_q   <= (seed == 16'd0) ? DEFAULT_SEED : seed;
      prompt_q <= 4'd0;
      active_q <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      score_q  <= 7'd0;
      round_q  <= 4'd0;
      over_q   <= 1'b0;
`ifdef NO_REPEAT_PROMPT_EN
      prev_idx_q <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      prompt_q <= prompt_d;
      active_q <= active_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      score_q  <= score_d;
      round_q  <= round_d;
      over_q   <= over_d;
`ifdef NO_REPEAT_PROMPT_EN
      prev_idx_q <= prev_idx_d;
`endif
    end
  end

  assign prompt        = prompt_q;
  assign prompt_active = active_q;
  assign hit           = hit_q;
  assign miss          = miss_q;
  assign score         = score_q;
  assign round         = round_q;
  assign game_over     = over_q;

endmodule

// File: tb/tb_prompt_sequencer.sv
// Directed bench for prompt_sequencer: vector table for one full game plus hand-written corner sequences.
module tb_prompt_sequencer;

  logic        clk;
  logic        resetn;
  logic [15:0] seed;
  logic        start;
  logic        btn_valid;
  logic [3:0]  btn_onehot;
  logic [3:0]  prompt;
  logic        prompt_active;
  logic        hit;
  logic        miss;
  logic [6:0]  score;
  logic [3:0]  round;
  logic        game_over;

  int n_cmp = 0;
  int n_bad = 0;

  prompt_sequencer #(
    .RESPONSE_CYCLES(8),
    .GAP_CYCLES(4),
    .MAX_ROUNDS(3),
    .DEFAULT_SEED(16'hACE1)
  ) dut (
    .CLOCK_50(clk),
    .resetn(resetn),
    .seed(seed),
    .start(start),
    .btn_valid(btn_valid),
    .btn_onehot(btn_onehot),
    .prompt(prompt),
    .prompt_active(prompt_active),
    .hit(hit),
    .miss(miss),
    .score(score),
    .round(round),
    .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR, stepped independently of the DUT.
  logic [15:0] m;
  always @(posedge clk) begin
    if (!resetn) m <= (seed == 16'd0) ? 16'hACE1 : seed;
    else         m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
  end

  logic [3:0] exp_prompt;
  logic [1:0] prev_idx;

  // Called just before the edge that enters SHOW, while m holds the value the DUT samples.
  task automatic predict(input bit first);
    logic [1:0] idx;
    idx = m[1:0];
`ifdef NO_REPEAT_PROMPT_EN
    if (!first && idx == prev_idx) idx = idx + 2'd1;
`endif
    prev_idx   = idx;
    exp_prompt = 4'b0001 << idx;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".prompt"}, int'(prompt), 0);
    chk({tag, ".active"}, int'(prompt_active), 0);
    chk({tag, ".hit"}, int'(hit), 0);
    chk({tag, ".miss"}, int'(miss), 0);
    chk({tag, ".score"}, int'(score), 0);
    chk({tag, ".round"}, int'(round), 0);
    chk({tag, ".over"}, int'(game_over), 0);
  endtask

  typedef struct {
    bit       st;
    bit       bv;
    bit [1:0] bsel;  // 0 literal bh, 1 current prompt, 2 prompt rotated by one
    bit [3:0] bh;
    bit [1:0] pk;    // 0 prompt zero, 1 prompt held, 2 fresh prompt this edge
    bit       eh;
    bit       em;
    int       esc;
    int       erd;
    bit       eact;
    bit       eov;
  } vec_t;

  function automatic vec_t mk(bit st, bit bv, bit [1:0] bsel, bit [3:0] bh, bit [1:0] pk,
                              bit eh, bit em, int esc, int erd, bit eact, bit eov);
    vec_t v;
    v.st = st; v.bv = bv; v.bsel = bsel; v.bh = bh; v.pk = pk;
    v.eh = eh; v.em = em; v.esc = esc; v.erd = erd; v.eact = eact; v.eov = eov;
    return v;
  endfunction

  localparam int NV = 21;
  vec_t tbl [NV];

  int rounds_done;
  int repeats;
  logic [3:0] prevp;

  initial begin
    //              st bv bsel  bh        pk    eh em sc rd act ov
    tbl[0]  = mk(1'b0, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 2'd0, 4'b0000, 2'd2, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 2'd0, 4'b0000, 2'd1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 2'd0, 4'b0000, 2'd1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 1'b1, 2'd1, 4'b0000, 2'd0, 1'b1, 1'b0, 1, 0, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 2'd0, 4'b0000, 2'd2, 1'b0, 1'b0, 1, 1, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 2'd0, 4'b0011, 2'd0, 1'b0, 1'b1, 1, 1, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0);
    tbl[13] = mk(1'b0, 1'b0, 2'd0, 4'b0000, 2'd2, 1'b0, 1'b0, 1, 2, 1'b1, 1'b0);
    tbl[14] = mk(1'b0, 1'b1, 2'd2, 4'b0000, 2'd0, 1'b0, 1'b1, 1, 2, 1'b0, 1'b0);
    tbl[15] = mk(1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 1'b0, 1, 2, 1'b0, 1'b0);
    tbl[16] = mk(1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 1'b0, 1, 2, 1'b0, 1'b0);
    tbl[17] = mk(1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 1'b0, 1, 2, 1'b0, 1'b0);
    tbl[18] = mk(1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 1'b0, 1, 3, 1'b0, 1'b1);
    tbl[19] = mk(1'b0, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b0, 1'b0, 1, 3, 1'b0, 1'b1);
    tbl[20] = mk(1'b1, 1'b0, 2'd0, 4'b0000, 2'd2, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);

    resetn = 1'b0; seed = 16'h0001; start = 1'b0; btn_valid = 1'b0; btn_onehot = 4'd0;
    exp_prompt = 4'd0; prev_idx = 2'd0;
    tick();
    tick();
    chk_reset("reset");
    resetn = 1'b1;

    // Game 1 and the restart into game 2.
    for (int i = 0; i < NV; i++) begin
      start     = tbl[i].st;
      btn_valid = tbl[i].bv;
      case (tbl[i].bsel)
        2'd1:    btn_onehot = exp_prompt;
        2'd2:    btn_onehot = {exp_prompt[2:0], exp_prompt[3]};
        default: btn_onehot = tbl[i].bh;
      endcase
      if (tbl[i].pk == 2'd2) predict(tbl[i].st);
      tick();
      start = 1'b0; btn_valid = 1'b0; btn_onehot = 4'd0;
      chk($sformatf("v%0d.hit", i), int'(hit), int'(tbl[i].eh));
      chk($sformatf("v%0d.miss", i), int'(miss), int'(tbl[i].em));
      chk($sformatf("v%0d.score", i), int'(score), tbl[i].esc);
      chk($sformatf("v%0d.round", i), int'(round), tbl[i].erd);
      chk($sformatf("v%0d.active", i), int'(prompt_active), int'(tbl[i].eact));
      chk($sformatf("v%0d.over", i), int'(game_over), int'(tbl[i].eov));
      chk($sformatf("v%0d.prompt", i), int'(prompt),
          (tbl[i].pk == 2'd0) ? 0 : int'(exp_prompt));
    end

    // Timeout: miss lands exactly 8 cycles after the prompt rose.
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("to%0d.miss", k), int'(miss), 0);
      chk($sformatf("to%0d.active", k), int'(prompt_active), 1);
    end
    tick();
    chk("to8.miss", int'(miss), 1);
    chk("to8.hit", int'(hit), 0);
    chk("to8.active", int'(prompt_active), 0);
    chk("to8.score", int'(score), 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("gap%0d.prompt", k), int'(prompt), 0);
    end
    predict(1'b0);
    tick();
    chk("r1.prompt", int'(prompt), int'(exp_prompt));
    chk("r1.round", int'(round), 1);

    // Correct press on the counter==0 cycle: hit wins, timeout dropped.
    for (int k = 1; k <= 7; k++) tick();
    chk("cz.pre_miss", int'(miss), 0);
    btn_valid = 1'b1; btn_onehot = exp_prompt;
    tick();
    btn_valid = 1'b0; btn_onehot = 4'd0;
    chk("cz.hit", int'(hit), 1);
    chk("cz.miss", int'(miss), 0);
    chk("cz.score", int'(score), 1);
    tick();
    chk("cz.hit_next", int'(hit), 0);
    chk("cz.miss_next", int'(miss), 0);
    tick();
    tick();
    predict(1'b0);
    tick();
    chk("r2.prompt", int'(prompt), int'(exp_prompt));
    chk("r2.round", int'(round), 2);
    chk("r2.active", int'(prompt_active), 1);

    // Reset mid-SHOW.
    resetn = 1'b0;
    tick();
    chk_reset("rst_show");
    resetn = 1'b1;

    // Reset mid-GAP.
    start = 1'b1;
    predict(1'b1);
    tick();
    start = 1'b0;
    chk("g3.prompt", int'(prompt), int'(exp_prompt));
    btn_valid = 1'b1; btn_onehot = exp_prompt;
    tick();
    btn_valid = 1'b0; btn_onehot = 4'd0;
    chk("g3.hit", int'(hit), 1);
    chk("g3.score", int'(score), 1);
    tick();
    resetn = 1'b0;
    tick();
    chk_reset("rst_gap");
    resetn = 1'b1;
    btn_valid = 1'b1; btn_onehot = 4'b0100;
    tick();
    btn_valid = 1'b0; btn_onehot = 4'd0;
    chk("idle_btn.hit", int'(hit), 0);
    chk("idle_btn.miss", int'(miss), 0);
    chk("idle_btn.prompt", int'(prompt), 0);

    // Zero seed falls back to the default seed.
    seed = 16'h0000;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    start = 1'b1;
    predict(1'b1);
    tick();
    start = 1'b0;
    chk("seed0.prompt", int'(prompt), int'(exp_prompt));

`ifdef NO_REPEAT_PROMPT_EN
    rounds_done = 0;
    repeats     = 0;
    prevp       = exp_prompt;
    btn_valid = 1'b1; btn_onehot = exp_prompt;
    rounds_done = 1;
    tick();
    btn_valid = 1'b0; btn_onehot = 4'd0;
    for (int k = 0; k < 20000 && rounds_done < 1000; k++) begin
      if (game_over) begin
        start = 1'b1;
        prevp = 4'd0;
      end else if (prompt != 4'd0) begin
        if (prompt == prevp) repeats++;
        prevp = prompt;
        btn_valid = 1'b1;
        btn_onehot = prompt;
        rounds_done++;
      end
      tick();
      start = 1'b0; btn_valid = 1'b0; btn_onehot = 4'd0;
    end
    chk("norep.rounds", rounds_done, 1000);
    chk("norep.repeats", repeats, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
